// File: rtl/mac_feeder.sv
// Sequences operand pairs into an external multiply-accumulate unit, one dot product at a time,
// and captures each finished accumulation behind a valid/ready result port.
module mac_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  input  logic                    flush,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [DATA_WIDTH-1:0]   mac_a,
  output logic [DATA_WIDTH-1:0]   mac_b,
  input  logic [3*DATA_WIDTH-1:0] mac_cout,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [3*DATA_WIDTH-1:0] res_data,
  output logic [7:0]              vec_count,
  output logic                    busy
);

  localparam int CW = $clog2(VEC_LEN + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    FEED    = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4,
    RESULT  = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    mac_en_q, mac_en_d;
  logic [DATA_WIDTH-1:0]   mac_a_q, mac_a_d;
  logic [DATA_WIDTH-1:0]   mac_b_q, mac_b_d;
  logic                    res_valid_q, res_valid_d;
  logic [3*DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [7:0]              vec_count_q, vec_count_d;
  logic                    in_hs;

  // Ready depends only on the state register and flush, never on in_valid.
  assign in_ready  = (state_q == FEED) && !flush;
  assign in_hs     = in_valid && in_ready;
  assign mac_clr   = (state_q == CLEAR);
  assign busy      = (state_q == CLEAR) || (state_q == FEED) ||
                     (state_q == DRAIN) || (state_q == CAPTURE);
  assign mac_en    = mac_en_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign vec_count = vec_count_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mac_en_d    = 1'b0;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    vec_count_d = vec_count_q;

    case (state_q)
      IDLE:  state_d = CLEAR;
      CLEAR: begin
        cnt_d   = '0;
        state_d = FEED;
      end
      FEED: begin
        if (in_hs) begin
          mac_en_d = 1'b1;
          mac_a_d  = in_a;
          mac_b_d  = in_b;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CW'(VEC_LEN - 1)) state_d = DRAIN;
        end
      end
      // The MAC consumes the final pair during DRAIN; its sum is visible in CAPTURE.
      DRAIN: state_d = CAPTURE;
      CAPTURE: begin
        res_data_d  = mac_cout;
        res_valid_d = 1'b1;
        state_d     = RESULT;
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          vec_count_d = vec_count_q + 8'd1;
          state_d     = CLEAR;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides any handshake decided above in the same cycle.
    if (flush) begin
      state_d     = CLEAR;
      mac_en_d    = 1'b0;
      res_valid_d = 1'b0;
      cnt_d       = '0;
      vec_count_d = vec_count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mac_en_q    <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      vec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mac_en_q    <= mac_en_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      vec_count_q <= vec_count_d;
    end
  end

endmodule
